mdu_arbiter: RTL
================

// Module: mdu_arbiter
// PURPOSE
//   Shares the single multiply/divide unit (MDU) between two requesters, e.g. core
//   execute stage (port 0) and a second client (port 1). Round-robin grant.
//   Issues the MDU one-cycle start pulse, holds operands stable until done, and
//   returns the registered result to the owner via a valid/ready response.
//   Enforces a watchdog timeout so a hung MDU cannot deadlock either requester.
// PARAMETERS
//   DATA_WIDTH      32  operand/result width
//   TIMEOUT_CYCLES  64  max cycles in WAIT before forced error response (>=2)
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   reset          in   1   asynchronous, active-low reset (0 = reset)
//   reqN_valid     in   1   N=0,1: request valid
//   reqN_ready     out  1   request accepted when valid&&ready
//   reqN_op        in   3   funct3 op: 000 MUL .. 111 REMU, passed through unchanged
//   reqN_x/reqN_y  in   DW  operands X, Y
//   rspN_valid     out  1   result valid for port N
//   rspN_ready     in   1   requester consumes result
//   rspN_data      out  DW  result
//   rspN_err       out  1   1 = timeout, data forced to all-ones
//   mdu_start      out  1   one-cycle start pulse to MDU
//   mdu_operation  out  3   latched op
//   mdu_in_x/y     out  DW  latched operands, stable from start until done
//   mdu_out        in   DW  MDU result, valid when mdu_done=1
//   mdu_done       in   1   MDU completion
//   busy           out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, every output and register 0, last_grant=1,
//     so port 0 wins the first tie. Reset mid-operation abandons the transaction
//     with no response. The MDU is reset by the same net.
//   FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: grant is combinational. Only one valid: that port wins. Both valid: port
//     != last_grant wins. reqN_ready=1 only for the granted port and only in IDLE.
//     On handshake, latch op/x/y and owner, set last_grant=owner, go to ISSUE.
//   ISSUE: mdu_start=1 for exactly this cycle. Clear timer. Go to WAIT.
//   WAIT: mdu_start=0. mdu_done=1 -> latch mdu_out into rsp data, err=0, go to RESP.
//     mdu_done is ignored outside WAIT. Timer increments each cycle. When the timer
//     reaches TIMEOUT_CYCLES with no done -> data=all-ones, err=1, go to RESP.
//     done and timeout on the same cycle: done wins.
//   RESP: rsp<owner>_valid=1, data/err held stable until rsp<owner>_ready=1, then
//     go to IDLE. The other port's rsp_valid stays 0. No new grant while in RESP.
//   Latency: accept at cycle T, mdu_start at T+1, done at D>=T+2, rsp_valid at D+1.
//     Minimum 3 cycles from accept to response. Throughput: one op per MDU latency+3.
//   mdu_operation/mdu_in_x/mdu_in_y hold the last latched values outside ISSUE/WAIT.
//   Arithmetic corner cases (div by zero, overflow) are the MDU's; data is passed
//     through unmodified.
// TESTING
//   1. req0 MUL x=5 y=3 -> mdu_start high exactly 1 cycle; rsp0_data=15, err=0;
//      rsp1_valid never asserts.
//   2. Post-reset, req0 DIV 15/3 and req1 DIVU 15/4 both valid -> req0 served first
//      (5), then req1 (3). A third simultaneous pair -> port 0 granted again.
//   3. req1 MULHU 0x8F4*0x357 with rsp1_ready low for 5 cycles -> rsp1_valid/data
//      held stable, req0_ready=0, no extra mdu_start. Releases on ready.
//   4. MDU model with mdu_done tied 0, TIMEOUT_CYCLES=8 -> after 8 WAIT cycles:
//      rsp0_valid=1, err=1, data=0xFFFFFFFF. busy returns to 0 after ready.
//   5. reset pulled low during WAIT -> all outputs 0 immediately. After release:
//      no stale rsp. Next tie granted to port 0.
//   6. req0 DIVU 0xFFFFFFFF/0 -> rsp0_data=0xFFFFFFFF, err=0 (MDU result passed through).

Source files
------------

// File: rtl/mdu_arbiter.sv
// Two-port round-robin arbiter in front of the shared multiply/divide unit.
// Owns the MDU for one transaction at a time: latches the winning request,
// pulses mdu_start once, waits for mdu_done under a watchdog, and returns the
// result to the owning port through a valid/ready response.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transaction; combinational grant, accepts one request
//   ST_ISSUE | mdu_start high for this single cycle, watchdog loaded
//   ST_WAIT  | operands held, waiting for mdu_done or watchdog expiry
//   ST_RESP  | result presented to owner until its rsp_ready
module mdu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_x,
    input  logic [DATA_WIDTH-1:0] req0_y,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_x,
    input  logic [DATA_WIDTH-1:0] req1_y,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_err,

    output logic                  mdu_start,
    output logic [2:0]            mdu_operation,
    output logic [DATA_WIDTH-1:0] mdu_in_x,
    output logic [DATA_WIDTH-1:0] mdu_in_y,
    input  logic [DATA_WIDTH-1:0] mdu_out,
    input  logic                  mdu_done,
    output logic                  busy
);

    // Watchdog is a down-counter: loaded with TIMEOUT_CYCLES-1 in ISSUE so the
    // terminal count (zero) is seen on the TIMEOUT_CYCLES-th WAIT cycle.
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  owner;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  grant_valid;
    logic                  grant_port;
    logic                  accept;
    logic                  owner_ready;

    // Round-robin pick: a lone requester wins, on a tie the port that did not
    // win last time wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_port  = ~last_grant;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
        end
    end

    // Ready is also gated by reset so both ready outputs read 0 while the
    // reset net is asserted, even with a request pending.
    assign accept      = (state == ST_IDLE) && grant_valid && reset;
    assign req0_ready  = accept && !grant_port;
    assign req1_ready  = accept && grant_port;
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    assign busy      = (state != ST_IDLE);
    assign rsp0_data = rsp_data;
    assign rsp1_data = rsp_data;
    assign rsp0_err  = rsp_err;
    assign rsp1_err  = rsp_err;

    // Transaction sequencer with registered MDU and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            timer         <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
            mdu_start     <= 1'b0;
            mdu_operation <= '0;
            mdu_in_x      <= '0;
            mdu_in_y      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner         <= grant_port;
                        last_grant    <= grant_port;
                        mdu_operation <= grant_port ? req1_op : req0_op;
                        mdu_in_x      <= grant_port ? req1_x  : req0_x;
                        mdu_in_y      <= grant_port ? req1_y  : req0_y;
                        mdu_start     <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mdu_start <= 1'b0;
                    timer     <= TMR_LOAD;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (mdu_done) begin
                        rsp_data   <= mdu_out;
                        rsp_err    <= 1'b0;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= ST_RESP;
                    end else if (timer == '0) begin
                        rsp_data   <= '1;
                        rsp_err    <= 1'b1;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= ST_RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
